// File: rtl/mux_sw_ctrl_pkg.sv
// Shared parameters, state encoding and capacitor-mask helpers for mux_sw_ctrl.
// Contents: CHANNEL_NUM, CAPACITOR_NUM, derived widths, state_e,
//           cap_thermo (n low ones), cap_rotl (rotate left within CAPACITOR_NUM bits).
package mux_sw_ctrl_pkg;

   localparam int unsigned CHANNEL_NUM   = 128;
   localparam int unsigned CAPACITOR_NUM = 70;

   // Pass grant count never exceeds CAPACITOR_NUM; job popcount can reach CHANNEL_NUM.
   localparam int unsigned CNT_W  = $clog2(CAPACITOR_NUM + 1);
   localparam int unsigned OFF_W  = $clog2(CAPACITOR_NUM);
   localparam int unsigned PCNT_W = $clog2(CHANNEL_NUM + 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } state_e;

   // n contiguous ones starting at bit 0.
   function automatic logic [CAPACITOR_NUM-1:0] cap_thermo(input logic [CNT_W-1:0] n);
      logic [CAPACITOR_NUM-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < CAPACITOR_NUM; i++) begin
         m[i] = (CNT_W'(i) < n);
      end
      return m;
   endfunction

   // Rotate left by off (off < CAPACITOR_NUM); bits leaving the top re-enter at bit 0.
   function automatic logic [CAPACITOR_NUM-1:0] cap_rotl(input logic [CAPACITOR_NUM-1:0] m,
                                                         input logic [OFF_W-1:0]         off);
      logic [2*CAPACITOR_NUM-1:0] d;
      d = {m, m} << off;
      return d[2*CAPACITOR_NUM-1:CAPACITOR_NUM];
   endfunction

endpackage

// File: rtl/mux_sw_ctrl_pass_select.sv
// pass_select: picks the lowest-index set bits of rem_i, at most CAPACITOR_NUM of them.
// Ports: rem_i   remaining channel mask
//        grant_c granted channels for this pass (combinational)
//        count_c number of granted channels
//        last_c  every remaining channel fits in this pass
module pass_select
   import mux_sw_ctrl_pkg::*;
(
   input  logic [CHANNEL_NUM-1:0] rem_i,
   output logic [CHANNEL_NUM-1:0] grant_c,
   output logic [CNT_W-1:0]       count_c,
   output logic                   last_c
);

   logic [PCNT_W-1:0] taken;
   logic [PCNT_W-1:0] total;

   // Priority scan from bit 0, saturating grants at CAPACITOR_NUM.
   always_comb begin
      grant_c = '0;
      taken   = '0;
      total   = '0;
      for (int unsigned i = 0; i < CHANNEL_NUM; i++) begin
         if (rem_i[i]) begin
            total = total + PCNT_W'(1);
            if (taken < PCNT_W'(CAPACITOR_NUM)) begin
               grant_c[i] = 1'b1;
               taken      = taken + PCNT_W'(1);
            end
         end
      end
      count_c = CNT_W'(taken);
      last_c  = (total <= PCNT_W'(CAPACITOR_NUM));
   end

endmodule

// File: rtl/mux_sw_ctrl.sv
// mux_sw_ctrl: splits a channel request mask into passes of at most CAPACITOR_NUM
// channels and drives the capacitor mux (din) and capacitor enables (sw).
// Ports: clk, rst_n (async active-low)
//        req_mask/req_valid/req_ready  job request handshake
//        abort                         drop the running job
//        din/sw/last/out_valid/out_ready  per-pass output handshake
//        busy                          job in progress
// Build option: MUX_SW_CTRL_ROTATE_EN rotates the capacitor start offset by the
// grant count of every completed pass; undefined, sw always fills from bit 0.
module mux_sw_ctrl
   import mux_sw_ctrl_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [CHANNEL_NUM-1:0]   req_mask,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     abort,
   output logic [CHANNEL_NUM-1:0]   din,
   output logic [CAPACITOR_NUM-1:0] sw,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     last,
   output logic                     busy
);

   state_e                   state_q;
   logic [CHANNEL_NUM-1:0]   rem_q;
   logic [CHANNEL_NUM-1:0]   din_q;
   logic [CAPACITOR_NUM-1:0] sw_q;
   logic                     last_q;
   logic                     out_valid_q;
   logic                     busy_q;
   logic                     req_ready_q;

   logic [CHANNEL_NUM-1:0]   sel_rem_c;
   logic [CHANNEL_NUM-1:0]   grant_c;
   logic [CNT_W-1:0]         count_c;
   logic                     last_c;
   logic                     accept_c;
   logic                     done_c;
   logic [CAPACITOR_NUM-1:0] sw_accept_c;
   logic [CAPACITOR_NUM-1:0] sw_next_c;

   // One selector serves both the first pass (from the incoming mask) and follow-on passes.
   assign sel_rem_c = (state_q == ST_IDLE) ? req_mask : (rem_q & ~din_q);
   assign accept_c  = (state_q == ST_IDLE) && req_valid && req_ready_q;
   assign done_c    = (state_q == ST_ISSUE) && !abort && out_ready;

   pass_select u_pass_select (
      .rem_i   (sel_rem_c),
      .grant_c (grant_c),
      .count_c (count_c),
      .last_c  (last_c)
   );

`ifdef MUX_SW_CTRL_ROTATE_EN
   logic [OFF_W-1:0]   offset_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [OFF_W:0]     offset_sum_c;
   logic [OFF_W-1:0]   offset_adv_c;

   // Offset after the current pass completes, modulo CAPACITOR_NUM.
   assign offset_sum_c = (OFF_W+1)'(offset_q) + (OFF_W+1)'(cnt_q);
   assign offset_adv_c = (offset_sum_c >= (OFF_W+1)'(CAPACITOR_NUM))
                         ? OFF_W'(offset_sum_c - (OFF_W+1)'(CAPACITOR_NUM))
                         : OFF_W'(offset_sum_c);
   assign sw_accept_c  = cap_rotl(cap_thermo(count_c), offset_q);
   assign sw_next_c    = cap_rotl(cap_thermo(count_c), offset_adv_c);

   // Offset survives across jobs; aborted passes do not advance it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         offset_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (accept_c) begin
            cnt_q <= count_c;
         end
         if (done_c) begin
            offset_q <= offset_adv_c;
            if (!last_q) begin
               cnt_q <= count_c;
            end
         end
      end
   end
`else
   assign sw_accept_c = cap_thermo(count_c);
   assign sw_next_c   = cap_thermo(count_c);
`endif

   // Control FSM with registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         rem_q       <= '0;
         din_q       <= '0;
         sw_q        <= '0;
         last_q      <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         req_ready_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               req_ready_q <= 1'b1;
               if (accept_c) begin
                  state_q     <= ST_ISSUE;
                  rem_q       <= req_mask;
                  din_q       <= grant_c;
                  sw_q        <= sw_accept_c;
                  last_q      <= last_c;
                  out_valid_q <= 1'b1;
                  busy_q      <= 1'b1;
                  req_ready_q <= 1'b0;
               end
            end
            ST_ISSUE: begin
               // abort takes priority over a handshake in the same cycle
               if (abort || (out_ready && last_q)) begin
                  state_q     <= ST_IDLE;
                  rem_q       <= '0;
                  din_q       <= '0;
                  sw_q        <= '0;
                  last_q      <= 1'b0;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  req_ready_q <= 1'b1;
               end else if (out_ready) begin
                  rem_q  <= sel_rem_c;
                  din_q  <= grant_c;
                  sw_q   <= sw_next_c;
                  last_q <= last_c;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready = req_ready_q;
   assign din       = din_q;
   assign sw        = sw_q;
   assign out_valid = out_valid_q;
   assign last      = last_q;
   assign busy      = busy_q;

endmodule

// File: doc/mux_sw_ctrl.md
MUX_SW_CTRL -- requirements
Module: mux_sw_ctrl

Interface
REQ-001 SHALL have parameters (from shared para header): CHANNEL_NUM, default 128, number of input channels; CAPACITOR_NUM, default 70, number of capacitor slots.
REQ-002 SHALL have ports:
  clk  in  1  single clock, all logic rising-edge.
  rst_n  in  1  asynchronous active-low reset.
  req_mask  in  CHANNEL_NUM  channels requesting capacitor assignment.
  req_valid  in  1  req_mask valid.
  req_ready  out  1  controller can accept a mask.
  abort  in  1  drop current job.
  din  out  CHANNEL_NUM  channels granted in current pass; feeds the capacitor mux.
  sw  out  CAPACITOR_NUM  capacitor enables for current pass.
  out_valid  out  1  din/sw pass valid.
  out_ready  in  1  downstream consumed pass.
  last  out  1  current pass is final pass of the job.
  busy  out  1  job in progress.

Function
REQ-003 SHALL implement FSM with states IDLE and ISSUE only.
REQ-004 IDLE: req_ready=1, out_valid=0, busy=0; on req_valid&req_ready, register req_mask into rem and go to ISSUE.
REQ-005 ISSUE: req_ready=0, busy=1, out_valid=1; all outputs registered, first out_valid exactly 1 cycle after the accept edge.
REQ-006 Each pass: din = lowest-index min(popcount(rem), CAPACITOR_NUM) set bits of rem; sw = that many contiguous ones starting at the capacitor start offset (REQ-014), all other bits 0.
REQ-007 last = 1 when popcount(rem) <= CAPACITOR_NUM.
REQ-008 On out_valid&out_ready with last=0: clear granted bits from rem, present next pass in the following cycle.
REQ-009 On out_valid&out_ready with last=1: return to IDLE; req_ready=1 the next cycle (no back-to-back accept in the same cycle).
REQ-010 While out_valid&!out_ready: din, sw, last SHALL remain stable.
REQ-011 Empty mask (all zeros) SHALL be accepted and produce one pass: din=0, sw=0, last=1.
REQ-012 abort in ISSUE: go to IDLE next cycle, outputs zeroed, rem cleared; abort wins over a simultaneous out_ready handshake; abort in IDLE SHALL be ignored (req accept still proceeds).

Reset
REQ-013 While rst_n=0: state=IDLE, rem=0, din=0, sw=0, out_valid=0, last=0, busy=0, req_ready=0; req_ready rises in the first cycle after reset release; reset mid-job discards the job without any further pass.

Configuration
REQ-014 Macro MUX_SW_CTRL_ROTATE_EN: when defined, capacitor start offset register (reset 0) advances by the pass's grant count modulo CAPACITOR_NUM on each completed pass, sw wraps from bit CAPACITOR_NUM-1 to bit 0; when undefined, offset is constant 0 and sw always fills from bit 0.

Structure
REQ-015 CHANNEL_NUM, CAPACITOR_NUM and the state encoding SHALL live in the shared para header; no local redefinition.
REQ-016 First-K set-bit selection (rem, K=CAPACITOR_NUM -> grant mask, count) SHALL be one combinational sub-module pass_select; FSM, rem, offset and output registers in mux_sw_ctrl.

Verification
REQ-017 Mask bits {3,40,127}, out_ready=1 -> one pass, din bits {3,40,127}, sw=0b111, last=1, out_valid 1 cycle after accept.
REQ-018 All 128 bits set -> pass 1: din bits 0..69, sw all ones, last=0; pass 2: din bits 70..127, sw 58 ones (bits 0..57 without ROTATE_EN; bits 0..57 rotated from offset 70 mod 70 = 0, i.e. also bits 0..57, with it), last=1.
REQ-019 Exactly 70 bits set -> single pass, sw all ones, last=1; mask 0 -> single pass din=0, sw=0, last=1.
REQ-020 out_ready held low 5 cycles during pass 1 of 128-bit job -> din/sw/last unchanged all 5 cycles, pass 2 follows release by 1 cycle.
REQ-021 abort asserted with out_ready in pass 1 -> IDLE next cycle, outputs 0, no pass 2; rst_n pulsed mid-job -> same result asynchronously.
REQ-022 ROTATE_EN: two jobs of 50 bits -> job 1 sw bits 0..49, job 2 sw bits 50..69 and 0..29.
